seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter TW, default 3, width of the T-state counter.
REQ-002 Parameter RST_CYCLES, default 7, length of the power-on/reset sequence in cycles (legal range 3..2^TW-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 rdy  input  1  cycle enable; low freezes sequencing.
REQ-006 op_len  input  TW  base cycle count of the loaded opcode, from the external decode ROM; valid from T1 onward.
REQ-007 extra  input  2  extra cycles for page-cross/branch-taken; valid in the last base cycle.
REQ-008 irq_n  input  1  level interrupt request, active-low.
REQ-009 nmi_n  input  1  non-maskable interrupt, falling-edge triggered.
REQ-010 p_i  input  1  interrupt-disable flag.
REQ-011 tstate  output  TW  current T-state; T0 = opcode fetch.
REQ-012 sync  output  1  high in every T0.
REQ-013 ir_ld  output  1  load IR from the data bus.
REQ-014 last_cycle  output  1  high in the final cycle of an instruction, interrupt or reset sequence.
REQ-015 force_brk  output  1  substitute opcode 0x00 for the fetched byte.
REQ-016 vector_sel  output  2  0 none, 1 NMI (FFFA), 2 RESET (FFFC), 3 IRQ/BRK (FFFE).
REQ-017 wr_inhibit  output  1  suppress memory writes.

Function
REQ-018 States: S_RESET, S_FETCH, S_EXEC, S_EXTRA, S_INT.
REQ-019 While rdy=0, state, tstate and all registered outputs SHALL hold, and NMI edge capture SHALL continue.
REQ-020 In S_RESET, tstate SHALL count 0..RST_CYCLES-1 with wr_inhibit=1 throughout and vector_sel=2 in the final two cycles, last_cycle=1 in the final cycle, then S_FETCH.
REQ-021 In S_FETCH (tstate=0): sync=1; with no pending interrupt, ir_ld=1 and next state S_EXEC, tstate=1.
REQ-022 In S_EXEC, tstate SHALL increment each enabled cycle; op_len values below 2 are treated as 2; the last base cycle is tstate=op_len-1.
REQ-023 In the last base cycle, extra=0 SHALL assert last_cycle and go to S_FETCH; extra=N>0 SHALL go to S_EXTRA for exactly N further cycles, with last_cycle in the last of them.
REQ-024 tstate SHALL saturate at 2^TW-1 and never wrap; sequence length is still governed by the cycle counts.
REQ-025 A falling edge on nmi_n (registered previous value 1, current value 0) SHALL set nmi_pend; nmi_pend SHALL clear in T5 of an NMI sequence; an edge arriving in that same T5 SHALL re-set nmi_pend.
REQ-026 An interrupt is pending at T0 if nmi_pend=1, or if irq_n=0 and p_i=0; NMI SHALL have priority over IRQ.
REQ-027 On a pending interrupt at T0: sync=1, ir_ld=1, force_brk=1, then S_INT; the interrupt type SHALL latch at T0.
REQ-028 S_INT SHALL last 7 cycles total (T0..T6); vector_sel SHALL be 1 or 3 per the latched type in T5 and T6; last_cycle=1 in T6; then S_FETCH.
REQ-029 An interrupt arising mid-instruction SHALL be recognised only at the next T0.
REQ-030 vector_sel SHALL be 0 outside the cycles named in REQ-020 and REQ-028; wr_inhibit SHALL be 0 outside S_RESET.

Reset
REQ-031 Asserting rst at any time SHALL force S_RESET, tstate=0, nmi_pend=0, nmi_n history=1, sync=0, ir_ld=0, last_cycle=0, force_brk=0, vector_sel=0 and wr_inhibit=1.
REQ-032 After release, the reset sequence SHALL start from T0 on the first enabled edge.

Configuration
REQ-033 With macro SEQ_INT_EN defined, REQ-025..REQ-029 apply.
REQ-034 Without SEQ_INT_EN: irq_n, nmi_n and p_i are ignored, S_INT and the NMI logic are absent, force_brk is tied to 0, and vector_sel only ever takes values 0 or 2.

Structure
REQ-035 Package seq_pkg SHALL hold the state enum, the vector_sel codes and INT_CYCLES=7.
REQ-036 Sub-module seq_nmi_detect SHALL contain the nmi_n edge register and the nmi_pend latch, with inputs for rdy-independent sampling and the T5 clear.

Verification
REQ-037 Release rst, rdy=1 -> 7 reset cycles with wr_inhibit=1, vector_sel=2 at T5 and T6, then sync=1 at T0.
REQ-038 op_len=4, extra=0 -> T0,T1,T2,T3 with last_cycle at T3; then op_len=2, extra=2 -> T0..T3 with last_cycle at T3.
REQ-039 rdy=0 for 3 cycles at T2 -> tstate holds 2 for 3 cycles, then resumes at 3.
REQ-040 irq_n=0 with p_i=1 -> no interrupt; then p_i=0 -> at next T0, force_brk=1 and 7-cycle sequence with vector_sel=3 at T5 and T6.
REQ-041 nmi_n pulse low for 1 cycle during T1 while irq_n=0, p_i=0 -> NMI taken at next T0 (vector_sel=1), then IRQ taken at the following T0.
REQ-042 rst asserted at T4 of S_INT -> immediate S_RESET values per REQ-031, with nmi_pend=0.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg
//  Purpose  : Shared state encodings, vector codes and interrupt sequence
//             length for the T-state sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Sequencer states
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_EXTRA = 3'd3;
    localparam logic [2:0] S_INT   = 3'd4;

    // vector_sel codes
    localparam logic [1:0] VEC_NONE  = 2'd0;   // no vector fetch
    localparam logic [1:0] VEC_NMI   = 2'd1;   // FFFA
    localparam logic [1:0] VEC_RESET = 2'd2;   // FFFC
    localparam logic [1:0] VEC_IRQ   = 2'd3;   // FFFE (IRQ/BRK)

    // Interrupt sequence length including the T0 fetch cycle
    localparam int INT_CYCLES = 7;

    // T-state in which the vector low byte is read and NMI is acknowledged
    localparam int INT_VEC_T = INT_CYCLES - 2;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_nmi_detect.sv
`default_nettype none
// ============================================================================
//  Module   : seq_nmi_detect
//  Purpose  : Falling-edge detector on nmi_n with a sticky pending flag.
//             Sampling runs every clock regardless of the cycle enable so
//             that edges arriving while the sequencer is frozen are kept.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_nmi_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_nmi_n,
    input  logic i_clr,
    output logic o_nmi_pend
);

    logic r_nmi_prev;
    logic r_nmi_pend;
    logic w_fall;

    assign w_fall     = r_nmi_prev & ~i_nmi_n;
    assign o_nmi_pend = r_nmi_pend;

    // Edge history and pending latch; a new edge wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_prev <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_prev <= i_nmi_n;
            if (w_fall) begin
                r_nmi_pend <= 1'b1;
            end else if (i_clr) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

endmodule : seq_nmi_detect
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ctrl
//  Purpose  : CPU T-state sequencer: reset sequence, opcode fetch, base and
//             extra execution cycles, and interrupt entry sequences.
//  Config   : SEQ_INT_EN - when defined, IRQ/NMI recognition and the S_INT
//             sequence are built; otherwise interrupt inputs are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int TW         = 3,
    parameter int RST_CYCLES = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic [TW-1:0] op_len,
    input  logic [1:0]    extra,
    input  logic          irq_n,
    input  logic          nmi_n,
    input  logic          p_i,
    output logic [TW-1:0] tstate,
    output logic          sync,
    output logic          ir_ld,
    output logic          last_cycle,
    output logic          force_brk,
    output logic [1:0]    vector_sel,
    output logic          wr_inhibit
);

    localparam logic [TW-1:0] c_tmax     = '1;
    localparam logic [TW-1:0] c_rst_last = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] c_rst_vec  = TW'(RST_CYCLES - 2);

    logic [2:0]    r_state;
    logic [TW-1:0] r_tstate;
    logic [1:0]    r_xcnt;      // remaining extra cycles, including current

    logic [2:0]    w_state_nx;
    logic [TW-1:0] w_t_nx;
    logic [1:0]    w_x_nx;
    logic [TW-1:0] w_len;
    logic [TW-1:0] w_base_last;
    logic [TW-1:0] w_tinc;
    logic          w_last;
    logic          w_brk;
    logic [1:0]    w_vsel;

    // Short opcodes still take a fetch plus one execute cycle
    assign w_len       = (op_len < TW'(2)) ? TW'(2) : op_len;
    assign w_base_last = w_len - TW'(1);
    // tstate saturates; the real sequence length comes from op_len/extra
    assign w_tinc      = (r_tstate == c_tmax) ? r_tstate : r_tstate + TW'(1);

`ifdef SEQ_INT_EN
    localparam logic [TW-1:0] c_int_vec  = TW'(INT_VEC_T);
    localparam logic [TW-1:0] c_int_last = TW'(INT_CYCLES - 1);

    logic r_int_nmi;
    logic w_nmi_pend;
    logic w_nmi_clr;
    logic w_int_pend;

    // Acknowledge NMI in the enabled vector-low cycle of an NMI sequence
    assign w_nmi_clr  = rdy & (r_state == S_INT) & (r_tstate == c_int_vec) & r_int_nmi;
    assign w_int_pend = w_nmi_pend | (~irq_n & ~p_i);

    seq_nmi_detect u_nmi (
        .clk        (clk),
        .rst        (rst),
        .i_nmi_n    (nmi_n),
        .i_clr      (w_nmi_clr),
        .o_nmi_pend (w_nmi_pend)
    );

    // Latch the interrupt type at T0 so a late NMI cannot change the vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_nmi <= 1'b0;
        end else if (rdy && (r_state == S_FETCH)) begin
            r_int_nmi <= w_nmi_pend;
        end
    end
`else
    logic w_unused_int;
    assign w_unused_int = irq_n ^ nmi_n ^ p_i;
`endif

    // Next-state, T-state and per-cycle output decode
    always_comb begin
        w_state_nx = r_state;
        w_t_nx     = r_tstate;
        w_x_nx     = r_xcnt;
        w_last     = 1'b0;
        w_brk      = 1'b0;
        w_vsel     = VEC_NONE;
        case (r_state)
            S_RESET: begin
                if (r_tstate >= c_rst_vec) begin
                    w_vsel = VEC_RESET;
                end
                if (r_tstate == c_rst_last) begin
                    w_last     = 1'b1;
                    w_state_nx = S_FETCH;
                    w_t_nx     = '0;
                end else begin
                    w_t_nx = w_tinc;
                end
            end
            S_FETCH: begin
                w_t_nx     = TW'(1);
                w_state_nx = S_EXEC;
`ifdef SEQ_INT_EN
                if (w_int_pend) begin
                    w_brk      = 1'b1;
                    w_state_nx = S_INT;
                end
`endif
            end
            S_EXEC: begin
                // >= guards against op_len shrinking mid-instruction
                if (r_tstate >= w_base_last) begin
                    if (extra == 2'd0) begin
                        w_last     = 1'b1;
                        w_state_nx = S_FETCH;
                        w_t_nx     = '0;
                    end else begin
                        w_state_nx = S_EXTRA;
                        w_x_nx     = extra;
                        w_t_nx     = w_tinc;
                    end
                end else begin
                    w_t_nx = w_tinc;
                end
            end
            S_EXTRA: begin
                if (r_xcnt <= 2'd1) begin
                    w_last     = 1'b1;
                    w_state_nx = S_FETCH;
                    w_t_nx     = '0;
                end else begin
                    w_x_nx = r_xcnt - 2'd1;
                    w_t_nx = w_tinc;
                end
            end
`ifdef SEQ_INT_EN
            S_INT: begin
                if (r_tstate >= c_int_vec) begin
                    w_vsel = r_int_nmi ? VEC_NMI : VEC_IRQ;
                end
                if (r_tstate == c_int_last) begin
                    w_last     = 1'b1;
                    w_state_nx = S_FETCH;
                    w_t_nx     = '0;
                end else begin
                    w_t_nx = w_tinc;
                end
            end
`endif
            default: begin
                w_state_nx = S_RESET;
                w_t_nx     = '0;
            end
        endcase
    end

    // Sequencer registers advance only on enabled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_RESET;
            r_tstate <= '0;
            r_xcnt   <= 2'd0;
        end else if (rdy) begin
            r_state  <= w_state_nx;
            r_tstate <= w_t_nx;
            r_xcnt   <= w_x_nx;
        end
    end

    assign tstate     = r_tstate;
    assign sync       = (r_state == S_FETCH);
    assign ir_ld      = (r_state == S_FETCH);
    assign last_cycle = w_last;
    assign force_brk  = w_brk;
    assign vector_sel = w_vsel;
    assign wr_inhibit = (r_state == S_RESET);

endmodule : seq_ctrl
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_ctrl
//  Purpose  : Self-checking bench for seq_ctrl. Each cycle's expected output
//             vector {tstate,sync,ir_ld,last,force_brk,vector_sel,wr_inhibit}
//             is queued when inputs are driven and compared mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [2:0] op_len;
    logic [1:0] extra;
    logic       irq_n;
    logic       nmi_n;
    logic       p_i;
    logic [2:0] tstate;
    logic       sync;
    logic       ir_ld;
    logic       last_cycle;
    logic       force_brk;
    logic [1:0] vector_sel;
    logic       wr_inhibit;

    logic [9:0] w_obs;
    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic [9:0] e;
    int         n_chk  = 0;
    int         n_pass = 0;

    assign w_obs = {tstate, sync, ir_ld, last_cycle, force_brk, vector_sel, wr_inhibit};

    always #5 clk = ~clk;

    seq_ctrl #(.TW(3), .RST_CYCLES(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .op_len     (op_len),
        .extra      (extra),
        .irq_n      (irq_n),
        .nmi_n      (nmi_n),
        .p_i        (p_i),
        .tstate     (tstate),
        .sync       (sync),
        .ir_ld      (ir_ld),
        .last_cycle (last_cycle),
        .force_brk  (force_brk),
        .vector_sel (vector_sel),
        .wr_inhibit (wr_inhibit)
    );

    // Build an expected output vector (sync and ir_ld are both T0-fetch flags)
    function automatic logic [9:0] mk(input int t, input bit s, input bit l,
                                      input bit fb, input int v, input bit wi);
        return {t[2:0], s, s, l, fb, v[1:0], wi};
    endfunction

    // Reset hold values, then the 7-cycle reset sequence
    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 2) rst = 1'b0;
            if (c < 2) exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
            else       exp_q.push_back(mk(c - 2, 0, (c - 2) == 6, 0, ((c - 2) >= 5) ? 2 : 0, 1));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL reset cycle %0d: got %b required %b", c, got, e);
            @(posedge clk); #1;
        end
    endtask

    // One instruction from T0 with no interrupt pending
    task automatic test_exec(input int len, input int ext, input string name);
        int l_base;
        int n;
        l_base = (len < 2) ? 2 : len;
        n      = l_base + ext;
        op_len = len[2:0];
        extra  = ext[1:0];
        for (int c = 0; c < n; c++) begin
            if (c == 0)           exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
            else if (c < l_base)  exp_q.push_back(mk(c, 0, (c == l_base - 1) && (ext == 0), 0, 0, 0));
            else                  exp_q.push_back(mk((c > 7) ? 7 : c, 0, c == n - 1, 0, 0, 0));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL %s cycle %0d: got %b required %b", name, c, got, e);
            @(posedge clk); #1;
        end
    endtask

    // rdy low for 3 cycles at T2 freezes the sequence
    task automatic test_rdy_hold();
        int ts[7];
        bit rd[7];
        ts = '{0, 1, 2, 2, 2, 2, 3};
        rd = '{1, 1, 0, 0, 0, 1, 1};
        op_len = 3'd4;
        extra  = 2'd0;
        for (int c = 0; c < 7; c++) begin
            rdy = rd[c];
            exp_q.push_back(mk(ts[c], ts[c] == 0, c == 6, 0, 0, 0));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL rdy_hold cycle %0d: got %b required %b", c, got, e);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
    endtask

    // Reset asserted in the middle of an instruction
    task automatic test_rst_mid();
        op_len = 3'd5;
        extra  = 2'd0;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(mk(c, c == 0, 0, 0, 0, 0));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL rst_mid cycle %0d: got %b required %b", c, got, e);
            @(posedge clk); #1;
        end
        test_reset();
    endtask

`ifdef SEQ_INT_EN
    // Seven-cycle interrupt entry starting at T0 with an interrupt pending
    task automatic test_int_seq(input int vec, input bit release_irq, input string name);
        for (int c = 0; c < 7; c++) begin
            if (c == 1 && release_irq) begin
                irq_n = 1'b1;
                p_i   = 1'b1;
            end
            if (c == 0) exp_q.push_back(mk(0, 1, 0, 1, 0, 0));
            else        exp_q.push_back(mk(c, 0, c == 6, 0, (c >= 5) ? vec : 0, 0));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL %s cycle %0d: got %b required %b", name, c, got, e);
            @(posedge clk); #1;
        end
    endtask

    // Masked IRQ is ignored; unmasking takes it at the next T0
    task automatic test_irq();
        irq_n = 1'b0;
        p_i   = 1'b1;
        test_exec(3, 0, "irq_masked");
        p_i = 1'b0;
        test_int_seq(3, 1'b1, "irq");
        test_exec(2, 0, "post_irq");
    endtask

    // NMI pulse mid-instruction with IRQ also pending: NMI first, then IRQ
    task automatic test_nmi();
        op_len = 3'd4;
        extra  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                irq_n = 1'b0;
                p_i   = 1'b0;
                nmi_n = 1'b0;
            end
            if (c == 2) nmi_n = 1'b1;
            exp_q.push_back(mk(c, c == 0, c == 3, 0, 0, 0));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL nmi_arm cycle %0d: got %b required %b", c, got, e);
            @(posedge clk); #1;
        end
        test_int_seq(1, 1'b0, "nmi");
        test_int_seq(3, 1'b1, "irq_after_nmi");
        test_exec(2, 0, "post_nmi_irq");
    endtask

    // Reset during T4 of an NMI sequence must also drop the pending NMI
    task automatic test_rst_int();
        op_len = 3'd2;
        extra  = 2'd0;
        for (int c = 0; c < 7; c++) begin
            nmi_n = (c == 0) ? 1'b0 : 1'b1;
            if (c == 6) rst = 1'b1;
            if (c == 0)      exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
            else if (c == 1) exp_q.push_back(mk(1, 0, 1, 0, 0, 0));
            else if (c == 2) exp_q.push_back(mk(0, 1, 0, 1, 0, 0));
            else if (c < 6)  exp_q.push_back(mk(c - 2, 0, 0, 0, 0, 0));
            else             exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
            @(negedge clk);
            got = w_obs; e = exp_q.pop_front(); n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL rst_int cycle %0d: got %b required %b", c, got, e);
            @(posedge clk); #1;
        end
        test_reset();
        test_exec(2, 0, "rst_clears_nmi");
    endtask
`else
    // Interrupt inputs have no effect when interrupts are not built
    task automatic test_int_ignored();
        irq_n = 1'b0;
        p_i   = 1'b0;
        nmi_n = 1'b0;
        test_exec(4, 0, "ign_a");
        nmi_n = 1'b1;
        test_exec(2, 1, "ign_b");
        irq_n = 1'b1;
        p_i   = 1'b1;
    endtask
`endif

    initial begin
        rst    = 1'b1;
        rdy    = 1'b1;
        op_len = 3'd0;
        extra  = 2'd0;
        irq_n  = 1'b1;
        nmi_n  = 1'b1;
        p_i    = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_exec(4, 0, "op4");
        test_exec(2, 2, "op2_x2");
        test_exec(0, 0, "op0_min");
        test_exec(1, 1, "op1_x1");
        test_exec(7, 3, "op7_x3_sat");
        test_rdy_hold();
`ifdef SEQ_INT_EN
        test_irq();
        test_nmi();
        test_rst_int();
`else
        test_int_ignored();
`endif
        test_rst_mid();
        test_exec(3, 1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_seq_ctrl
`default_nettype wire
